// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for eight 7-segment digits behind a
// 3-8 decoder. Each digit goes dark for BLANK_CYC cycles, then is lit for
// DIV cycles. New DATA/DP words are held in a pending register and only
// move to the display at the start of a frame, so a frame never mixes old
// and new digits.
// Optional feature: define LZ_BLANK_EN to blank leading zeros (digits 7..1).
module seg7_scan #(
   parameter int unsigned DIV       = 50000,
   parameter int unsigned BLANK_CYC = 4
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        EN,
   input  logic        LOAD,
   input  logic [31:0] DATA,
   input  logic [7:0]  DP,
   output logic [2:0]  A,
   output logic        G1,
   output logic        G2,
   output logic        G3,
   output logic [7:0]  SEG,
   output logic        FRAME
);

   localparam int unsigned MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
   localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    digit_q, digit_d;
   logic [31:0]   pend_data_q, pend_data_d;
   logic [7:0]    pend_dp_q, pend_dp_d;
   logic [31:0]   disp_data_q, disp_data_d;
   logic [7:0]    disp_dp_q, disp_dp_d;
   logic [2:0]    a_q, a_d;
   logic          g1_q, g1_d;
   logic          g2_q, g2_d;
   logic [7:0]    seg_q, seg_d;
   logic          frame_q, frame_d;
   logic          enter_frame;
   logic [7:0]    lead_zero;
   logic [3:0]    cur_nibble;

   // Standard hex to {g,f,e,d,c,b,a} segment pattern.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   // Scan sequencer: dropping EN always wins and parks the scan at digit 0.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      digit_d     = digit_q;
      frame_d     = 1'b0;
      enter_frame = 1'b0;
      if (!EN) begin
         state_d = IDLE;
         cnt_d   = '0;
         digit_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d     = BLANK;
               cnt_d       = '0;
               digit_d     = '0;
               enter_frame = 1'b1;
            end
            BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = SHOW;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            SHOW: begin
               if (cnt_q == SHOW_LAST) begin
                  state_d = BLANK;
                  cnt_d   = '0;
                  digit_d = digit_q + 3'd1;
                  if (digit_q == 3'd7) begin
                     frame_d     = 1'b1;
                     enter_frame = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               digit_d = '0;
            end
         endcase
      end
   end

   // Pending captures every LOAD; display refreshes only at frame start,
   // taking a same-cycle LOAD directly so it is not a frame late.
   always_comb begin
      pend_data_d = pend_data_q;
      pend_dp_d   = pend_dp_q;
      disp_data_d = disp_data_q;
      disp_dp_d   = disp_dp_q;
      if (LOAD) begin
         pend_data_d = DATA;
         pend_dp_d   = DP;
      end
      if (enter_frame) begin
         disp_data_d = pend_data_d;
         disp_dp_d   = pend_dp_d;
      end
   end

`ifdef LZ_BLANK_EN
   // Leading-zero mask: walk down from digit 7 until a nonzero nibble or a DP.
   always_comb begin
      logic run;
      lead_zero = '0;
      run       = 1'b1;
      for (int k = 7; k >= 1; k--) begin
         if (run && (disp_data_d[4*k +: 4] == 4'h0) && !disp_dp_d[k]) begin
            lead_zero[k] = 1'b1;
         end else begin
            run = 1'b0;
         end
      end
   end
`else
   assign lead_zero = '0;
`endif

   assign cur_nibble = disp_data_d[{digit_d, 2'b00} +: 4];

   // Output values for the state being entered, so the registered pins
   // always match the current state.
   always_comb begin
      a_d   = '0;
      g1_d  = 1'b0;
      g2_d  = 1'b1;
      seg_d = '0;
      case (state_d)
         BLANK: begin
            a_d = digit_d;
         end
         SHOW: begin
            a_d  = digit_d;
            g1_d = 1'b1;
            g2_d = 1'b0;
            if (!lead_zero[digit_d]) begin
               seg_d = {disp_dp_d[digit_d], hex7(cur_nibble)};
            end
         end
         default: ;
      endcase
   end

   // All state and output registers.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         digit_q     <= '0;
         pend_data_q <= '0;
         pend_dp_q   <= '0;
         disp_data_q <= '0;
         disp_dp_q   <= '0;
         a_q         <= '0;
         g1_q        <= 1'b0;
         g2_q        <= 1'b1;
         seg_q       <= '0;
         frame_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         digit_q     <= digit_d;
         pend_data_q <= pend_data_d;
         pend_dp_q   <= pend_dp_d;
         disp_data_q <= disp_data_d;
         disp_dp_q   <= disp_dp_d;
         a_q         <= a_d;
         g1_q        <= g1_d;
         g2_q        <= g2_d;
         seg_q       <= seg_d;
         frame_q     <= frame_d;
      end
   end

   assign A     = a_q;
   assign G1    = g1_q;
   assign G2    = g2_q;
   assign G3    = 1'b0;
   assign SEG   = seg_q;
   assign FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Testbench for seg7_scan with DIV=3, BLANK_CYC=2 (5 cycles per digit,
// 40 cycles per frame). Expected segment values are hand-written per case.
module tb_seg7_scan;

   logic        CLK;
   logic        RSTN;
   logic        EN;
   logic        LOAD;
   logic [31:0] DATA;
   logic [7:0]  DP;
   logic [2:0]  A;
   logic        G1;
   logic        G2;
   logic        G3;
   logic [7:0]  SEG;
   logic        FRAME;

   int checks;
   int errors;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  dp;
      logic [63:0] exp_seg;
      string       name;
   } vec_t;

   vec_t vecs[6];

   seg7_scan #(.DIV(3), .BLANK_CYC(2)) dut (
      .CLK(CLK), .RSTN(RSTN), .EN(EN), .LOAD(LOAD), .DATA(DATA), .DP(DP),
      .A(A), .G1(G1), .G2(G2), .G3(G3), .SEG(SEG), .FRAME(FRAME)
   );

   // Free-running 10-unit clock.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Drive inputs, then advance one rising edge and settle 1 unit past it.
   task automatic applyStimulus(input logic en, input logic load,
                                input logic [31:0] data, input logic [7:0] dp);
      EN   = en;
      LOAD = load;
      DATA = data;
      DP   = dp;
      @(posedge CLK);
      #1;
      LOAD = 1'b0;
   endtask

   // Compare all outputs against expected values.
   task automatic checkOutput(input string name, input logic [2:0] ea,
                              input logic eg1, input logic eg2,
                              input logic [7:0] eseg, input logic efr);
      checks++;
      if ({A, G1, G2, G3, SEG, FRAME} !== {ea, eg1, eg2, 1'b0, eseg, efr}) begin
         errors++;
         $display("[TB] FAIL %s: got A=%0d G1=%b G2=%b G3=%b SEG=%02h FRAME=%b, expected A=%0d G1=%b G2=%b G3=0 SEG=%02h FRAME=%b",
                  name, A, G1, G2, G3, SEG, FRAME, ea, eg1, eg2, eseg, efr);
      end
   endtask

   // One full frame from BLANK of digit 0; optional LOAD at tick load_at.
   task automatic checkFrame(input logic [63:0] exp_seg, input logic first_frame,
                             input int load_at, input string name);
      int t;
      t = 0;
      for (int d = 0; d < 8; d++) begin
         for (int c = 0; c < 5; c++) begin
            t++;
            applyStimulus(1'b1, (t == load_at), DATA, DP);
            if (c < 2)
               checkOutput($sformatf("%s d%0d c%0d", name, d, c), 3'(d), 1'b0, 1'b1,
                           8'h00, (d == 0 && c == 0) ? first_frame : 1'b0);
            else
               checkOutput($sformatf("%s d%0d c%0d", name, d, c), 3'(d), 1'b1, 1'b0,
                           exp_seg[8*d +: 8], 1'b0);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;

      vecs[0] = '{32'h76543210, 8'h00, 64'h077D6D664F5B063F, "count"};
      vecs[1] = '{32'hFFFFFFFF, 8'h00, 64'h7171717171717171, "allF"};
`ifdef LZ_BLANK_EN
      vecs[2] = '{32'h00000120, 8'h00, 64'h0000000000065B3F, "lz120"};
`else
      vecs[2] = '{32'h00000120, 8'h00, 64'h3F3F3F3F3F065B3F, "lz120"};
`endif
      vecs[3] = '{32'h89ABCDEF, 8'hA5, 64'hFF6FF77C39DE79F1, "hexDp"};
`ifdef LZ_BLANK_EN
      vecs[4] = '{32'h00000000, 8'h00, 64'h000000000000003F, "zeros"};
      vecs[5] = '{32'h00000000, 8'h10, 64'h000000BF3F3F3F3F, "zerosDp4"};
`else
      vecs[4] = '{32'h00000000, 8'h00, 64'h3F3F3F3F3F3F3F3F, "zeros"};
      vecs[5] = '{32'h00000000, 8'h10, 64'h3F3F3FBF3F3F3F3F, "zerosDp4"};
`endif

      RSTN = 1'b0;
      EN   = 1'b0;
      LOAD = 1'b0;
      DATA = '0;
      DP   = '0;
      #12;
      checkOutput("reset", 3'd0, 1'b0, 1'b1, 8'h00, 1'b0);
      #4 RSTN = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 8'h0);
      checkOutput("idleAfterReset", 3'd0, 1'b0, 1'b1, 8'h00, 1'b0);

      // Table: load while idle, enable, check two consecutive frames.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b0, DATA, DP);
         checkOutput({vecs[i].name, " idle"}, 3'd0, 1'b0, 1'b1, 8'h00, 1'b0);
         applyStimulus(1'b0, 1'b1, vecs[i].data, vecs[i].dp);
         checkOutput({vecs[i].name, " loaded"}, 3'd0, 1'b0, 1'b1, 8'h00, 1'b0);
         checkFrame(vecs[i].exp_seg, 1'b0, -1, {vecs[i].name, " f1"});
         checkFrame(vecs[i].exp_seg, 1'b1, -1, {vecs[i].name, " f2"});
      end

      // LOAD while digit 4 lit: current frame unchanged, next frame all F.
      applyStimulus(1'b0, 1'b0, DATA, DP);
      applyStimulus(1'b0, 1'b1, 32'h76543210, 8'h00);
      DATA = 32'hFFFFFFFF;
      DP   = 8'h00;
      checkFrame(64'h077D6D664F5B063F, 1'b0, 24, "ldMid");
      checkFrame(64'h7171717171717171, 1'b1, -1, "ldNext");

      // LOAD coincident with digit-0 entry is shown in that same frame.
      DATA = 32'h00000008;
      DP   = 8'h01;
`ifdef LZ_BLANK_EN
      checkFrame(64'h00000000000000FF, 1'b1, 1, "bypass");
`else
      checkFrame(64'h3F3F3F3F3F3F3FFF, 1'b1, 1, "bypass");
`endif

      // EN dropped during digit 5 SHOW, raised 10 cycles later.
      applyStimulus(1'b0, 1'b0, DATA, DP);
      for (int i = 1; i <= 27; i++) applyStimulus(1'b1, 1'b0, DATA, DP);
      applyStimulus(1'b1, 1'b0, DATA, DP);
`ifdef LZ_BLANK_EN
      checkOutput("d5Show", 3'd5, 1'b1, 1'b0, 8'h00, 1'b0);
`else
      checkOutput("d5Show", 3'd5, 1'b1, 1'b0, 8'h3F, 1'b0);
`endif
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, (i == 4), 32'h89ABCDEF, 8'hA5);
         checkOutput($sformatf("enLow %0d", i), 3'd0, 1'b0, 1'b1, 8'h00, 1'b0);
      end
      checkFrame(64'hFF6FF77C39DE79F1, 1'b0, -1, "reEnable");

      // Asynchronous reset in the middle of digit 3 SHOW.
      applyStimulus(1'b0, 1'b0, DATA, DP);
      for (int i = 1; i <= 17; i++) applyStimulus(1'b1, 1'b0, DATA, DP);
      applyStimulus(1'b1, 1'b0, DATA, DP);
      checkOutput("d3Show", 3'd3, 1'b1, 1'b0, 8'h39, 1'b0);
      #2 RSTN = 1'b0;
      #1;
      checkOutput("rstMid", 3'd0, 1'b0, 1'b1, 8'h00, 1'b0);
      #2 RSTN = 1'b1;
      checkFrame(vecs[4].exp_seg, 1'b0, -1, "afterRst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
